// File: rtl/block_spawner_if.sv
// Beatmap ROM read bus between block_spawner (master) and the beatmap BRAM (slave).
// Read protocol: no valid/ready; map_data holds mem[map_addr] exactly ROM_LATENCY cycles after map_addr is presented.
interface block_spawner_if #(
  parameter int MAP_ADDR_W = 8
);
  logic [MAP_ADDR_W-1:0] map_addr;
  logic [45:0]           map_data;

  modport master (output map_addr, input map_data);
  modport slave  (input map_addr, output map_data);
endinterface

// File: rtl/block_spawner.sv
// Song scheduler: walks the beatmap in time order and fills the block table, retiring hit or late blocks.
// Optional: define SPAWNER_MISS_COUNT_EN to build the saturating timeout-miss counter.
module block_spawner #(
  parameter int NUM_BLOCKS  = 12,
  parameter int MAP_ADDR_W  = 8,
  parameter int ROM_LATENCY = 2,
  parameter int LOOKAHEAD   = 150,
  parameter int DESPAWN     = 10
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        start_in,
  input  logic [17:0]                 curr_time_in,
  input  logic [NUM_BLOCKS-1:0]       hit_in,
  block_spawner_if.master             map_bus,
  output logic [NUM_BLOCKS-1:0][11:0] block_x_out,
  output logic [NUM_BLOCKS-1:0][11:0] block_y_out,
  output logic [NUM_BLOCKS-1:0][17:0] block_time_out,
  output logic [NUM_BLOCKS-1:0]       block_color_out,
  output logic [NUM_BLOCKS-1:0][2:0]  block_direction_out,
  output logic [NUM_BLOCKS-1:0]       block_visible_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [7:0]                  miss_count_out,
  output logic [2:0]                  state_dbg_out
);

  localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam int IDX_W  = $clog2(NUM_BLOCKS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                        state_q, state_d;
  logic [MAP_ADDR_W-1:0]         addr_q, addr_d;
  logic [WAIT_W-1:0]             wait_q, wait_d;
  logic [45:0]                   entry_q, entry_d;
  logic [NUM_BLOCKS-1:0][11:0]   x_q, x_d, y_q, y_d;
  logic [NUM_BLOCKS-1:0][17:0]   time_q, time_d;
  logic [NUM_BLOCKS-1:0]         color_q, color_d;
  logic [NUM_BLOCKS-1:0][2:0]    dir_q, dir_d;
  logic [NUM_BLOCKS-1:0]         visible_q, visible_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;

  logic [17:0]           e_time;
  logic                  e_sentinel, e_stale, e_due;
  logic                  has_free, last_addr, alloc, advance;
  logic [IDX_W-1:0]      free_idx;
  logic [NUM_BLOCKS-1:0] timeout, retire;

  // Window tests use 19-bit sums so times near 18'h3FFFF cannot wrap.
  assign e_time     = entry_q[21:4];
  assign e_sentinel = (e_time == 18'h3FFFF);
  assign e_stale    = {1'b0, curr_time_in} > ({1'b0, e_time} + 19'(DESPAWN));
  assign e_due      = {1'b0, e_time} <= ({1'b0, curr_time_in} + 19'(LOOKAHEAD));
  assign has_free   = ~&visible_q;
  assign last_addr  = &addr_q;
  assign alloc      = (state_q == S_CHECK) && !e_sentinel && !e_stale && e_due && has_free;
  assign advance    = (state_q == S_CHECK) && !e_sentinel && (e_stale || (e_due && has_free));

  always_comb begin
    free_idx = '0;
    for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
      if (!visible_q[i]) free_idx = IDX_W'(i);
    end
  end

  always_comb begin
    timeout = '0;
    retire  = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      timeout[i] = visible_q[i] && ({1'b0, curr_time_in} > ({1'b0, time_q[i]} + 19'(DESPAWN)));
      retire[i]  = (hit_in[i] && visible_q[i]) || timeout[i];
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_in) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  if (wait_q == '0) state_d = S_CHECK;
      S_CHECK: begin
        if (e_sentinel)   state_d = S_DRAIN;
        else if (advance) state_d = last_addr ? S_DRAIN : S_FETCH;
      end
      S_DRAIN: if (visible_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    addr_d    = addr_q;
    wait_d    = wait_q;
    entry_d   = entry_q;
    x_d       = x_q;
    y_d       = y_q;
    time_d    = time_q;
    color_d   = color_q;
    dir_d     = dir_q;
    visible_d = visible_q & ~retire;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          addr_d    = '0;
          busy_d    = 1'b1;
          x_d       = '0;
          y_d       = '0;
          time_d    = '0;
          color_d   = '0;
          dir_d     = '0;
          visible_d = '0;
        end
      end
      S_FETCH: wait_d = WAIT_W'(ROM_LATENCY - 1);
      S_WAIT: begin
        if (wait_q != '0) wait_d  = wait_q - 1'b1;
        else              entry_d = map_bus.map_data;
      end
      S_CHECK: begin
        // The free mask is last cycle's visible vector, so a just-retired slot waits one cycle.
        if (alloc) begin
          x_d[free_idx]       = entry_q[45:34];
          y_d[free_idx]       = entry_q[33:22];
          time_d[free_idx]    = entry_q[21:4];
          color_d[free_idx]   = entry_q[3];
          dir_d[free_idx]     = entry_q[2:0];
          visible_d[free_idx] = 1'b1;
        end
        if (advance && !last_addr) addr_d = addr_q + 1'b1;
      end
      S_DRAIN: begin
        if (visible_q == '0) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_q    <= '0;
      wait_q    <= '0;
      entry_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      time_q    <= '0;
      color_q   <= '0;
      dir_q     <= '0;
      visible_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wait_q    <= wait_d;
      entry_q   <= entry_d;
      x_q       <= x_d;
      y_q       <= y_d;
      time_q    <= time_d;
      color_q   <= color_d;
      dir_q     <= dir_d;
      visible_q <= visible_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef SPAWNER_MISS_COUNT_EN
  logic [7:0] miss_q, miss_d;
  logic [4:0] miss_inc;
  logic [8:0] miss_sum;

  // A slot hit in the same cycle it times out counts as a hit, not a miss.
  always_comb begin
    miss_inc = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      miss_inc = miss_inc + 5'(timeout[i] && !hit_in[i]);
    end
    miss_sum = {1'b0, miss_q} + 9'(miss_inc);
    if ((state_q == S_IDLE) && start_in) miss_d = '0;
    else if (miss_sum[8])                miss_d = 8'hFF;
    else                                 miss_d = miss_sum[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) miss_q <= '0;
    else        miss_q <= miss_d;
  end

  assign miss_count_out = miss_q;
`else
  assign miss_count_out = '0;
`endif

  assign map_bus.map_addr    = addr_q;
  assign block_x_out         = x_q;
  assign block_y_out         = y_q;
  assign block_time_out      = time_q;
  assign block_color_out     = color_q;
  assign block_direction_out = dir_q;
  assign block_visible_out   = visible_q;
  assign busy_out            = busy_q;
  assign done_out            = done_q;
  assign state_dbg_out       = state_q;

endmodule

// File: tb/tb_block_spawner.sv
// Directed bench for block_spawner with a two-stage registered beatmap ROM model.
module tb_block_spawner;

  localparam int NB = 12;

  logic               clk_in;
  logic               rst_in;
  logic               start_in;
  logic [17:0]        curr_time_in;
  logic [NB-1:0]      hit_in;
  logic [NB-1:0][11:0] block_x_out, block_y_out;
  logic [NB-1:0][17:0] block_time_out;
  logic [NB-1:0]       block_color_out;
  logic [NB-1:0][2:0]  block_direction_out;
  logic [NB-1:0]       block_visible_out;
  logic               busy_out, done_out;
  logic [7:0]         miss_count_out;
  logic [2:0]         state_dbg_out;

  int checks = 0;
  int errors = 0;

  logic [45:0] mem [256];
  logic [45:0] rom_p1, rom_p2;

  block_spawner_if #(.MAP_ADDR_W(8)) map_bus ();

  block_spawner dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .curr_time_in        (curr_time_in),
    .hit_in              (hit_in),
    .map_bus             (map_bus.master),
    .block_x_out         (block_x_out),
    .block_y_out         (block_y_out),
    .block_time_out      (block_time_out),
    .block_color_out     (block_color_out),
    .block_direction_out (block_direction_out),
    .block_visible_out   (block_visible_out),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .miss_count_out      (miss_count_out),
    .state_dbg_out       (state_dbg_out)
  );

  // Clock / reset and ROM model
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    rom_p1 <= mem[map_bus.map_addr];
    rom_p2 <= rom_p1;
  end
  assign map_bus.map_data = rom_p2;

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] entry(input int x, input int y, input int t, input int c, input int d);
    return {12'(x), 12'(y), 18'(t), 1'(c), 3'(d)};
  endfunction

  // Driver tasks
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 256; i++) mem[i] = entry(0, 0, 18'h3FFFF, 0, 0);
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick(2);
    rst_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
  endtask

  task automatic wait_vis(input string tag, input logic [NB-1:0] target, input int budget);
    int n;
    n = 0;
    while (block_visible_out !== target && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, block_visible_out, target);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_out !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, done_out, 1'b1);
  endtask

  initial begin
    int lat;
    rst_in       = 1'b0;
    start_in     = 1'b0;
    curr_time_in = '0;
    hit_in       = '0;
    clear_map();
    do_reset();

    check("rst_visible", block_visible_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_addr", map_bus.map_addr, 0);
    check("rst_state", state_dbg_out, 0);

    // First spawn and its latency from the start edge
    mem[0] = entry(200, 200, 150, 1, 2);
    pulse_start();
    check("busy_after_start", busy_out, 1);
    lat = 0;
    while (block_visible_out == '0 && lat < 20) begin
      tick(1);
      lat++;
    end
    check("spawn_latency", 64'(lat), 4);
    check("spawn_visible", block_visible_out, 12'h001);
    check("spawn_x0", block_x_out[0], 200);
    check("spawn_y0", block_y_out[0], 200);
    check("spawn_t0", block_time_out[0], 150);
    check("spawn_c0", block_color_out[0], 1);
    check("spawn_d0", block_direction_out[0], 2);

    // Timeout retire boundary: 160 keeps the block, 165 retires it
    tick(8);
    check("drain_state", state_dbg_out, 4);
    curr_time_in = 18'd160;
    tick(2);
    check("grace_160", block_visible_out[0], 1);
    curr_time_in = 18'd165;
    tick(1);
    check("timeout_165", block_visible_out[0], 0);
`ifdef SPAWNER_MISS_COUNT_EN
    check("miss_count", miss_count_out, 1);
`else
    check("miss_count", miss_count_out, 0);
`endif
    wait_done("done_song1", 10);
    check("busy_at_done", busy_out, 0);
    tick(1);
    check("done_one_cycle", done_out, 0);
    check("idle_after_done", state_dbg_out, 0);

    // Spawn window: t=400 spawns at curr=250, not at 245
    do_reset();
    clear_map();
    mem[0] = entry(1, 2, 400, 0, 1);
    curr_time_in = '0;
    pulse_start();
    for (int ct = 0; ct <= 250; ct += 5) begin
      curr_time_in = 18'(ct);
      tick(2);
      if (ct == 245) check("window_245", block_visible_out, 12'h000);
      if (ct == 250) check("window_250", block_visible_out, 12'h001);
    end

    // Table full stall and refill after a hit
    do_reset();
    clear_map();
    for (int i = 0; i < 13; i++) mem[i] = entry(i, 0, 150, 0, 0);
    curr_time_in = 18'd10;
    pulse_start();
    wait_vis("fill_all", 12'hFFF, 200);
    check("fill_x4", block_x_out[4], 4);
    check("fill_x11", block_x_out[11], 11);
    tick(10);
    check("stall_state", state_dbg_out, 3);
    check("stall_visible", block_visible_out, 12'hFFF);
    hit_in = 12'h010;
    tick(1);
    hit_in = '0;
    check("hit_clears", block_visible_out, 12'hFEF);
    tick(1);
    check("refill_visible", block_visible_out, 12'hFFF);
    check("refill_x4", block_x_out[4], 12);

    // Stale entry dropped, next entry lands in slot 0
    do_reset();
    clear_map();
    mem[0] = entry(55, 0, 20, 0, 0);
    mem[1] = entry(77, 3, 200, 1, 5);
    curr_time_in = 18'd100;
    pulse_start();
    wait_vis("stale_next_vis", 12'h001, 30);
    check("stale_x0", block_x_out[0], 77);
    check("stale_t0", block_time_out[0], 200);
    hit_in = 12'h002;
    tick(1);
    hit_in = '0;
    check("hit_invisible_ignored", block_visible_out, 12'h001);

    // Five visible, start ignored mid-song, then reset mid-song
    do_reset();
    clear_map();
    for (int i = 0; i < 5; i++) mem[i] = entry(i + 1, 9, 150, 1, 3);
    mem[5] = entry(99, 9, 1000, 0, 0);
    curr_time_in = 18'd10;
    pulse_start();
    wait_vis("five_visible", 12'h01F, 100);
    tick(5);
    check("five_state", state_dbg_out, 3);
    check("five_addr", map_bus.map_addr, 5);
    pulse_start();
    check("start_ignored_addr", map_bus.map_addr, 5);
    check("start_ignored_vis", block_visible_out, 12'h01F);
    rst_in = 1'b1;
    tick(1);
    rst_in = 1'b0;
    check("midrst_visible", block_visible_out, 0);
    check("midrst_x", 64'(block_x_out[4:0]), 0);
    check("midrst_time", 64'(block_time_out[2:0]), 0);
    check("midrst_color", block_color_out, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_done", done_out, 0);
    check("midrst_addr", map_bus.map_addr, 0);
    check("midrst_state", state_dbg_out, 0);
    check("midrst_miss", miss_count_out, 0);

    // Sentinel with empty table: single done pulse
    clear_map();
    pulse_start();
    wait_done("sentinel_done", 20);
    check("sentinel_busy", busy_out, 0);
    check("sentinel_vis", block_visible_out, 0);
    tick(1);
    check("sentinel_done_low", done_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
